// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR search controller family.
package sar_pkg;

  localparam int SAR_WIDTH_DEF  = 4;
  localparam int SAR_SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

  // Flag vector is {less, equal, greater}; a healthy comparator raises exactly one.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Bus between the SAR controller (master) and its comparator/requester side (slave).
interface sar_search_ctrl_if #(
  parameter int WIDTH = 4
);
  // start is a level request sampled on each edge; it is taken only when the
  // controller is not busy. done pulses for one cycle with result/hit/err stable.
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             cmp_less;
  logic             cmp_equal;
  logic             cmp_greater;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             hit;
  logic             err;

  modport master (
    input  start, cmp_less, cmp_equal, cmp_greater,
    output guess, busy, done, result, hit, err
  );

  modport slave (
    output start, cmp_less, cmp_equal, cmp_greater,
    input  guess, busy, done, result, hit, err
  );
endinterface

// File: rtl/sar_settle_timer.sv
// Loadable down-counter that parks at zero; o_zero marks the last cycle of a window.
module sar_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search against an external comparator.
// Optional flag-coding check enabled by defining SAR_ONEHOT_CHECK_EN.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH  = SAR_WIDTH_DEF,
  parameter int SETTLE = SAR_SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sar_search_ctrl_if.master  io_bus,
  output sar_state_t         o_dbg_state
);

  localparam int               IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int               CNT_W     = 4;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] GUESS_MSB = WIDTH'(1) << (WIDTH - 1);

  sar_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_guess, w_guess_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [WIDTH-1:0] w_decided;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_hit, w_hit_nxt;
  logic             r_done, w_done_nxt;
  logic             w_load;
  logic             w_zero;
  logic             w_trial;
  logic             w_bad;

  assign w_trial = (r_state == TRIAL);

  sar_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (SETTLE_LD),
    .i_en    (w_trial),
    .o_zero  (w_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_guess_nxt  = r_guess;
    w_idx_nxt    = r_idx;
    w_result_nxt = r_result;
    w_hit_nxt    = r_hit;
    w_done_nxt   = 1'b0;
    w_load       = 1'b0;
    w_decided    = r_guess;
    case (r_state)
      IDLE, DONE: begin
        if (io_bus.start) begin
          w_state_nxt = TRIAL;
          w_guess_nxt = GUESS_MSB;
          w_idx_nxt   = IDX_MSB;
          w_load      = 1'b1;
        end
      end
      TRIAL: begin
        if (w_zero) begin
          // Greater means the trial overshot, so the bit under test is dropped.
          if (io_bus.cmp_greater) w_decided[r_idx] = 1'b0;
          if (w_bad) begin
            w_state_nxt  = DONE;
            w_done_nxt   = 1'b1;
            w_result_nxt = '0;
            w_hit_nxt    = 1'b0;
          end else if (io_bus.cmp_equal) begin
            w_state_nxt  = DONE;
            w_done_nxt   = 1'b1;
            w_result_nxt = r_guess;
            w_hit_nxt    = 1'b1;
          end else if (r_idx == '0) begin
            w_state_nxt  = DONE;
            w_done_nxt   = 1'b1;
            w_result_nxt = w_decided;
            w_hit_nxt    = 1'b0;
          end else begin
            w_guess_nxt                = w_decided;
            w_guess_nxt[r_idx - 1'b1]  = 1'b1;
            w_idx_nxt                  = r_idx - 1'b1;
            w_load                     = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_guess  <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_hit    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_guess  <= w_guess_nxt;
      r_idx    <= w_idx_nxt;
      r_result <= w_result_nxt;
      r_hit    <= w_hit_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef SAR_ONEHOT_CHECK_EN
  logic r_err;
  logic w_err_nxt;

  assign w_bad = !is_onehot3({io_bus.cmp_less, io_bus.cmp_equal, io_bus.cmp_greater});

  always_comb begin
    w_err_nxt = r_err;
    if ((r_state != TRIAL) && io_bus.start) begin
      w_err_nxt = 1'b0;
    end else if (w_trial && w_zero && w_bad) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign io_bus.err = r_err;
`else
  // Without the check, all-zero flags fall through to the keep-bit (Less) path.
  assign w_bad      = 1'b0;
  assign io_bus.err = 1'b0;
`endif

  assign io_bus.guess  = r_guess;
  assign io_bus.busy   = w_trial;
  assign io_bus.done   = r_done;
  assign io_bus.result = r_result;
  assign io_bus.hit    = r_hit;
  assign o_dbg_state   = r_state;

endmodule
